// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared state encoding, opcodes, ALU codes and mux-select codes
// for the multicycle controller.
package risc_v_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALWB
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // C=1 means no borrow, so unsigned less-than is !C
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, n, c, v);
        return f3 == 3'b000 ? z :
               f3 == 3'b001 ? !z :
               f3 == 3'b100 ? n ^ v :
               f3 == 3'b101 ? !(n ^ v) :
               f3 == 3'b110 ? !c :
               f3 == 3'b111 ? c : 1'b0;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: ALU operation for R-type and I-type execute states;
// subtract is only possible for R-type (funct7 bit 5 is immediate data in I-type).
module mc_alu_decoder
    import risc_v_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_r,
    output logic [2:0] alu_ctl
);
    always_comb
        alu_ctl = funct3 == 3'b000 ? (is_r && funct7_5 ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010 ? ALU_SLT :
                  funct3 == 3'b110 ? ALU_OR  :
                  funct3 == 3'b111 ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control FSM.
// Define MC_MEM_WAIT_EN to stall memory states on MemReady.
module mc_controller
    import risc_v_pkg::*;
#(
    parameter int OP_WIDTH       = 7,
    parameter int FUNCT3_WIDTH   = 3,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int IMM_SRC_WIDTH  = 2
)
(
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [OP_WIDTH-1:0]       op,
    input  logic [FUNCT3_WIDTH-1:0]   funct3,
    input  logic                      funct7_5,
    input  logic                      Zero,
    input  logic                      N,
    input  logic                      C,
    input  logic                      V,
    input  logic                      MemReady,
    output logic                      MemReq,
    output logic                      PCWrite,
    output logic                      IRWrite,
    output logic                      MemWrite,
    output logic                      RegWrite,
    output logic                      AdrSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [1:0]                ResultSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
    output logic                      IllegalInstr,
    output logic [3:0]                State
);
    state_t     state, next;
    logic       mem_ok, legal;
    logic [2:0] dec_alu, alu_sel;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ok = 1'b1;
`endif

    assign legal = op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_IMM ||
                   op == OP_BRANCH || op == OP_JAL || op == OP_JALR;

    mc_alu_decoder u_alu_dec (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_r     (state == S_EXECR),
        .alu_ctl  (dec_alu)
    );

    always_comb begin
        next = S_FETCH;
        case (state)
            S_RESET:          next = S_FETCH;
            S_FETCH:          next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE:         next = op == OP_LOAD || op == OP_STORE ? S_MEMADR :
                                     op == OP_R      ? S_EXECR  :
                                     op == OP_IMM    ? S_EXECI  :
                                     op == OP_BRANCH ? S_BRANCH :
                                     op == OP_JAL    ? S_JAL    :
                                     op == OP_JALR   ? S_JALR   : S_FETCH;
            S_MEMADR:         next = op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:        next = mem_ok ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:       next = mem_ok ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI: next = S_ALUWB;
            S_JAL, S_JALR:    next = S_JALWB;
            default:          next = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state <= S_RESET;
        else        state <= next;

    always_comb begin
        MemReq       = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        AdrSrc       = 1'b0;
        IllegalInstr = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ResultSrc    = RES_ALUOUT;
        alu_sel      = ALU_ADD;
        case (state)
            S_FETCH:          begin MemReq = 1'b1; IRWrite = mem_ok; PCWrite = mem_ok; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES; end
            S_DECODE:         begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; IllegalInstr = !legal; end
            S_MEMADR:         begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
            S_EXECI:          begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; alu_sel = dec_alu; end
            S_EXECR:          begin ALUSrcA = SRCA_RS1; alu_sel = dec_alu; end
            S_MEMREAD:        begin MemReq = 1'b1; AdrSrc = 1'b1; end
            S_MEMWB:          begin ResultSrc = RES_DATA; RegWrite = 1'b1; end
            S_MEMWRITE:       begin MemReq = 1'b1; AdrSrc = 1'b1; MemWrite = mem_ok; end
            S_ALUWB:          RegWrite = 1'b1;
            S_BRANCH:         begin ALUSrcA = SRCA_RS1; alu_sel = ALU_SUB; PCWrite = branch_taken(funct3, Zero, N, C, V); end
            S_JAL:            PCWrite = 1'b1;
            S_JALR:           begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURES; PCWrite = 1'b1; end
            S_JALWB:          begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES; RegWrite = 1'b1; end
            default:          ;
        endcase
    end

    assign ALUControl = ALU_CTRL_WIDTH'(alu_sel);
    assign ImmSrc = IMM_SRC_WIDTH'(state == S_RESET ? IMM_I :
                                   op == OP_STORE   ? IMM_S :
                                   op == OP_BRANCH  ? IMM_B :
                                   op == OP_JAL     ? IMM_J : IMM_I);
    assign State = state;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven instruction sequences with a scoreboard queue,
// plus hand-written reset-abort and memory-wait sequences.
module tb_mc_controller;
    import risc_v_pkg::*;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0, Zero = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0, MemReady = 1'b1;
    logic       MemReq, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, IllegalInstr;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [17:0] outs;

    int n_checks = 0, n_err = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, n, c, v;
        int         lat;
        logic [3:0] s2;
        logic [2:0] alu;
        logic       pcw;
        logic [1:0] imm;
        logic       ill, rw, mw;
    } vec_t;

    vec_t vecs[21];
    vec_t exp_q[$];

    mc_controller dut (
        .CLK(CLK), .RST_N(RST_N), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .N(N), .C(C), .V(V), .MemReady(MemReady),
        .MemReq(MemReq), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .IllegalInstr(IllegalInstr), .State(State)
    );

    always #5 CLK = ~CLK;

    assign outs = {MemReq, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, IllegalInstr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at a negedge with the DUT in FETCH
    task automatic run_vec(input int idx, input vec_t v);
        int k;
        logic rw, mw;
        vec_t e;
        op = v.op; funct3 = v.f3; funct7_5 = v.f7;
        Zero = v.z; N = v.n; C = v.c; V = v.v;
        exp_q.push_back(v);
        chk($sformatf("v%0d_start", idx), State, 4'(S_FETCH));
        k = 0; rw = 1'b0; mw = 1'b0;
        do begin
            @(negedge CLK);
            k++;
            if (k == 1) begin
                chk($sformatf("v%0d_imm", idx), ImmSrc, v.imm);
                chk($sformatf("v%0d_ill", idx), IllegalInstr, v.ill);
            end
            if (k == 2) begin
                chk($sformatf("v%0d_state2", idx), State, v.s2);
                chk($sformatf("v%0d_alu", idx), ALUControl, v.alu);
                chk($sformatf("v%0d_pcw", idx), PCWrite, v.pcw);
                chk($sformatf("v%0d_ill_off", idx), IllegalInstr, 1'b0);
            end
            if (State != 4'(S_FETCH)) begin
                rw |= RegWrite;
                mw |= MemWrite;
            end
        end while (State != 4'(S_FETCH) && k < 12);
        e = exp_q.pop_front();
        chk($sformatf("v%0d_latency", idx), k, e.lat);
        chk($sformatf("v%0d_regwrite", idx), rw, e.rw);
        chk($sformatf("v%0d_memwrite", idx), mw, e.mw);
    endtask

    initial begin
        //           op          f3     f7 z  n  c  v  lat s2          alu      pcw imm    ill rw mw
        vecs[0]  = '{OP_LOAD,   3'b010, 0, 0, 0, 0, 0, 5, S_MEMADR,   ALU_ADD, 0, IMM_I, 0, 1, 0};
        vecs[1]  = '{OP_STORE,  3'b010, 0, 0, 0, 0, 0, 4, S_MEMADR,   ALU_ADD, 0, IMM_S, 0, 0, 1};
        vecs[2]  = '{OP_R,      3'b000, 0, 0, 0, 0, 0, 4, S_EXECR,    ALU_ADD, 0, IMM_I, 0, 1, 0};
        vecs[3]  = '{OP_R,      3'b000, 1, 0, 0, 0, 0, 4, S_EXECR,    ALU_SUB, 0, IMM_I, 0, 1, 0};
        vecs[4]  = '{OP_R,      3'b110, 0, 0, 0, 0, 0, 4, S_EXECR,    ALU_OR,  0, IMM_I, 0, 1, 0};
        vecs[5]  = '{OP_R,      3'b111, 1, 0, 0, 0, 0, 4, S_EXECR,    ALU_AND, 0, IMM_I, 0, 1, 0};
        vecs[6]  = '{OP_R,      3'b010, 0, 0, 0, 0, 0, 4, S_EXECR,    ALU_SLT, 0, IMM_I, 0, 1, 0};
        vecs[7]  = '{OP_R,      3'b001, 1, 0, 0, 0, 0, 4, S_EXECR,    ALU_ADD, 0, IMM_I, 0, 1, 0};
        vecs[8]  = '{OP_IMM,    3'b000, 1, 0, 0, 0, 0, 4, S_EXECI,    ALU_ADD, 0, IMM_I, 0, 1, 0};
        vecs[9]  = '{OP_IMM,    3'b010, 0, 0, 0, 0, 0, 4, S_EXECI,    ALU_SLT, 0, IMM_I, 0, 1, 0};
        vecs[10] = '{OP_BRANCH, 3'b000, 0, 1, 0, 0, 0, 3, S_BRANCH,   ALU_SUB, 1, IMM_B, 0, 0, 0};
        vecs[11] = '{OP_BRANCH, 3'b000, 0, 0, 0, 0, 0, 3, S_BRANCH,   ALU_SUB, 0, IMM_B, 0, 0, 0};
        vecs[12] = '{OP_BRANCH, 3'b001, 0, 0, 0, 0, 0, 3, S_BRANCH,   ALU_SUB, 1, IMM_B, 0, 0, 0};
        vecs[13] = '{OP_BRANCH, 3'b100, 0, 0, 1, 0, 0, 3, S_BRANCH,   ALU_SUB, 1, IMM_B, 0, 0, 0};
        vecs[14] = '{OP_BRANCH, 3'b101, 0, 0, 1, 0, 1, 3, S_BRANCH,   ALU_SUB, 1, IMM_B, 0, 0, 0};
        vecs[15] = '{OP_BRANCH, 3'b110, 0, 0, 0, 1, 0, 3, S_BRANCH,   ALU_SUB, 0, IMM_B, 0, 0, 0};
        vecs[16] = '{OP_BRANCH, 3'b111, 0, 0, 0, 1, 0, 3, S_BRANCH,   ALU_SUB, 1, IMM_B, 0, 0, 0};
        vecs[17] = '{OP_BRANCH, 3'b010, 0, 1, 1, 1, 0, 3, S_BRANCH,   ALU_SUB, 0, IMM_B, 0, 0, 0};
        vecs[18] = '{OP_JAL,    3'b000, 0, 0, 0, 0, 0, 4, S_JAL,      ALU_ADD, 1, IMM_J, 0, 1, 0};
        vecs[19] = '{OP_JALR,   3'b000, 0, 0, 0, 0, 0, 4, S_JALR,     ALU_ADD, 1, IMM_I, 0, 1, 0};
        vecs[20] = '{7'b0000000,3'b000, 0, 0, 0, 0, 0, 2, S_FETCH,    ALU_ADD, 1, IMM_I, 1, 0, 0};

        repeat (2) @(negedge CLK);
        chk("reset_state", State, 4'(S_RESET));
        chk("reset_outs", outs, 18'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("first_fetch", State, 4'(S_FETCH));
        chk("fetch_outs", outs, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 2'b00, 1'b0});

        for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

        // reset asserted in the middle of MEMWRITE aborts the store at once
        op = OP_STORE; funct3 = 3'b010;
        repeat (3) @(negedge CLK);
        chk("abort_in_memwrite", State, 4'(S_MEMWRITE));
        chk("abort_memwrite_on", MemWrite, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_memwrite_off", MemWrite, 1'b0);
        chk("abort_state", State, 4'(S_RESET));
        chk("abort_outs", outs, 18'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 chk("abort_held", State, 4'(S_RESET));
        @(negedge CLK);
        chk("abort_refetch", State, 4'(S_FETCH));

`ifdef MC_MEM_WAIT_EN
        op = OP_LOAD; MemReady = 1'b1;
        repeat (3) @(negedge CLK);
        chk("wait_memread", State, 4'(S_MEMREAD));
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("wait_hold%0d", i), State, 4'(S_MEMREAD));
            chk($sformatf("wait_memreq%0d", i), MemReq, 1'b1);
        end
        MemReady = 1'b1;
        @(negedge CLK);
        chk("wait_memwb", State, 4'(S_MEMWB));
        chk("wait_regwrite", RegWrite, 1'b1);
        chk("wait_resultsrc", ResultSrc, 2'b01);
        @(negedge CLK);
        chk("wait_refetch", State, 4'(S_FETCH));
`else
        MemReady = 1'b0;
        run_vec(100, vecs[0]);
        run_vec(101, vecs[1]);
        MemReady = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
